// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, cent values and payout states shared with the vending FSM
package vend_pkg;

  localparam int NUM_COINS = 5;

  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b011;
  localparam logic [2:0] COIN_HALF    = 3'b100;
  localparam logic [2:0] COIN_DOLLAR  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } payout_state_e;

  function automatic logic [6:0] coin_cents(input logic [2:0] code);
    case (code)
      COIN_NICKEL:  coin_cents = 7'd5;
      COIN_DIME:    coin_cents = 7'd10;
      COIN_QUARTER: coin_cents = 7'd25;
      COIN_HALF:    coin_cents = 7'd50;
      COIN_DOLLAR:  coin_cents = 7'd100;
      default:      coin_cents = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/payout_tube.sv
// rtl/payout_tube.sv - per-denomination coin inventory counter, saturating on restock
module payout_tube #(
  parameter int unsigned INIT_COUNT = 20,
  parameter int unsigned TUBE_DEPTH = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [4:0] count,
  output logic       nonempty
);

  logic [4:0] count_q, count_d;

  // A coin in and a coin out on the same edge cancel, even when the tube is full.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q < 5'(TUBE_DEPTH))) begin
      count_d = count_q + 5'd1;
    end else if (dec && !inc && (count_q != 5'd0)) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 5'(INIT_COUNT);
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign nonempty = (count_q != 5'd0);

endmodule

// File: rtl/coin_payout_sequencer.sv
// rtl/coin_payout_sequencer.sv - latches change counts and pulses one ejector at a time, largest coin first
module coin_payout_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned TUBE_DEPTH   = 31,
  parameter int unsigned INIT_COUNT   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [4:0]  nickel_req,
  input  logic [4:0]  dime_req,
  input  logic [4:0]  quarter_req,
  input  logic [4:0]  half_req,
  input  logic [4:0]  dollar_req,
  input  logic        restock,
  input  logic [2:0]  restock_sel,
  output logic [4:0]  eject,
  output logic        busy,
  output logic        done,
  output logic [12:0] shortfall_cents,
  output logic        nickel_s,
  output logic        dime_s,
  output logic        quarter_s,
  output logic        half_dollar_s,
  output logic        dollar_s,
  output logic        nickels19
);

  payout_state_e state_q, state_d;
  logic [4:0]  pend_q [NUM_COINS];
  logic [4:0]  pend_d [NUM_COINS];
  logic [2:0]  sel_idx_q, sel_idx_d;
  logic [15:0] timer_q, timer_d;
  logic [12:0] short_q, short_d;

  logic [4:0] tube_inc, tube_dec, tube_nz;
  logic [4:0] tube_cnt [NUM_COINS];

  logic       any_pend;
  logic [2:0] pick_idx;

  // Index 0 is the nickel tube, index 4 the dollar tube; coin code = index + 1.
  for (genvar i = 0; i < NUM_COINS; i++) begin : g_tube
    assign tube_inc[i] = restock && (restock_sel == 3'(i + 1));

    payout_tube #(
      .INIT_COUNT (INIT_COUNT),
      .TUBE_DEPTH (TUBE_DEPTH)
    ) u_tube (
      .clk      (clk),
      .rst      (rst),
      .inc      (tube_inc[i]),
      .dec      (tube_dec[i]),
      .count    (tube_cnt[i]),
      .nonempty (tube_nz[i])
    );
  end

  // Ascending scan so the highest-value pending denomination wins.
  always_comb begin
    any_pend = 1'b0;
    pick_idx = 3'd0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (pend_q[i] != 5'd0) begin
        any_pend = 1'b1;
        pick_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    sel_idx_d = sel_idx_q;
    timer_d   = timer_q;
    short_d   = short_q;
    tube_dec  = 5'd0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pend_d[0] = nickel_req;
          pend_d[1] = dime_req;
          pend_d[2] = quarter_req;
          pend_d[3] = half_req;
          pend_d[4] = dollar_req;
          short_d   = 13'd0;
          state_d   = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (!any_pend) begin
          state_d = ST_DONE;
        end else if (tube_cnt[pick_idx] != 5'd0) begin
          pend_d[pick_idx]   = pend_q[pick_idx] - 5'd1;
          tube_dec[pick_idx] = 1'b1;
          sel_idx_d          = pick_idx;
          timer_d            = 16'd0;
          state_d            = ST_PULSE;
        end else begin
          // Empty tube: write off the whole remaining count of this coin in one step.
          short_d = short_q + 13'(pend_q[pick_idx]) * 13'(coin_cents(pick_idx + 3'd1));
          pend_d[pick_idx] = 5'd0;
        end
      end

      ST_PULSE: begin
        if (timer_q == 16'(PULSE_CYCLES - 1)) begin
          timer_d = 16'd0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_GAP: begin
        if (timer_q == 16'(GAP_CYCLES - 1)) begin
          timer_d = 16'd0;
          state_d = ST_SELECT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_idx_q <= 3'd0;
      timer_q   <= 16'd0;
      short_q   <= 13'd0;
      for (int i = 0; i < NUM_COINS; i++) begin
        pend_q[i] <= 5'd0;
      end
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
      timer_q   <= timer_d;
      short_q   <= short_d;
      for (int i = 0; i < NUM_COINS; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // Eject decodes straight from registered state, so it can only ever be one-hot or zero.
  assign eject           = (state_q == ST_PULSE) ? (5'b00001 << sel_idx_q) : 5'b00000;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign shortfall_cents = short_q;

  assign nickel_s      = tube_nz[0];
  assign dime_s        = tube_nz[1];
  assign quarter_s     = tube_nz[2];
  assign half_dollar_s = tube_nz[3];
  assign dollar_s      = tube_nz[4];
  assign nickels19     = (tube_cnt[0] >= 5'd19);

endmodule
